// File: rtl/uart_pkg.sv
// Shared UART definitions: state encoding, frame geometry and a frame-length helper.
// Used by the transmitter and intended for reuse by the matching receiver.
package uart_pkg;

    localparam int unsigned DATA_BITS  = 8;
    localparam int unsigned START_BITS = 1;
    localparam int unsigned STATE_W    = 3;
    localparam int unsigned BIT_IDX_W  = $clog2(DATA_BITS);

    typedef logic [STATE_W-1:0] uart_state_t;

    localparam uart_state_t ST_IDLE   = 3'd0;
    localparam uart_state_t ST_START  = 3'd1;
    localparam uart_state_t ST_DATA   = 3'd2;
    localparam uart_state_t ST_PARITY = 3'd3;
    localparam uart_state_t ST_STOP   = 3'd4;

    // Number of serial bit periods in one frame for a given configuration.
    function automatic int unsigned frame_bits(input int unsigned parity_en,
                                               input int unsigned stop_bits);
        return START_BITS + DATA_BITS + parity_en + stop_bits;
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period timer: pulses bit_done_c on the last cycle of every CLKS_PER_BIT-cycle period.
// reload restarts the period at RELOAD_VAL (a receiver uses a mid-bit value for sampling).
module uart_baud_gen #(
    parameter int unsigned CLKS_PER_BIT = 87,
    parameter int unsigned RELOAD_VAL   = 0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic reload,
    output logic bit_done_c
);

    localparam int unsigned     CNT_W    = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(RELOAD_VAL);

    logic [CNT_W-1:0] cnt;

    // Wrapping at the end of a period is the per-bit reload.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (reload) begin
            cnt <= CNT_INIT;
        end else if (cnt == CNT_LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign bit_done_c = (cnt == CNT_LAST);

endmodule

// File: rtl/uart_tx.sv
// Byte-wide UART transmitter with valid/ready input, LSB first, optional parity, 1 or 2 stops.
// All outputs, including the serial line, come straight from flops.
module uart_tx
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 87,
    parameter int unsigned PARITY_EN    = 0,
    parameter int unsigned PARITY_ODD   = 0,
    parameter int unsigned STOP_BITS    = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 ena,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 tx,
    output logic                 busy
);

    localparam logic                 HAS_PARITY    = (PARITY_EN != 0);
    localparam logic                 ODD_BIT       = 1'(PARITY_ODD);
    localparam logic [BIT_IDX_W-1:0] LAST_DATA_IDX = BIT_IDX_W'(DATA_BITS - 1);
    localparam logic [BIT_IDX_W-1:0] LAST_STOP_IDX = BIT_IDX_W'(STOP_BITS - 1);

    uart_state_t          state, state_next;
    logic [DATA_BITS-1:0] shreg, shreg_next;
    logic [BIT_IDX_W-1:0] bit_idx, bit_idx_next;
    logic                 parity, parity_next;
    logic                 tx_next, busy_next, tx_ready_next;
    logic                 accept_c, reload_c, bit_done_c;

    // ena is checked again so a same-cycle ena drop never starts a frame.
    assign accept_c = tx_valid && tx_ready && ena;
    assign reload_c = (state == ST_IDLE);

    uart_baud_gen #(
        .CLKS_PER_BIT(CLKS_PER_BIT),
        .RELOAD_VAL  (0)
    ) u_baud (
        .clk       (clk),
        .rst_n     (rst_n),
        .reload    (reload_c),
        .bit_done_c(bit_done_c)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            tx       <= 1'b1;
            busy     <= 1'b0;
            tx_ready <= 1'b0;
            shreg    <= '0;
            bit_idx  <= '0;
            parity   <= 1'b0;
        end else begin
            state    <= state_next;
            tx       <= tx_next;
            busy     <= busy_next;
            tx_ready <= tx_ready_next;
            shreg    <= shreg_next;
            bit_idx  <= bit_idx_next;
            parity   <= parity_next;
        end
    end

    always_comb begin
        state_next   = state;
        tx_next      = tx;
        busy_next    = busy;
        shreg_next   = shreg;
        bit_idx_next = bit_idx;
        parity_next  = parity;

        case (state)
            ST_IDLE: begin
                tx_next   = 1'b1;
                busy_next = 1'b0;
                if (accept_c) begin
                    state_next   = ST_START;
                    tx_next      = 1'b0;
                    busy_next    = 1'b1;
                    shreg_next   = tx_data;
                    bit_idx_next = '0;
                    parity_next  = (^tx_data) ^ ODD_BIT;
                end
            end
            ST_START: begin
                if (bit_done_c) begin
                    state_next   = ST_DATA;
                    tx_next      = shreg[0];
                    bit_idx_next = '0;
                end
            end
            ST_DATA: begin
                if (bit_done_c) begin
                    if (bit_idx == LAST_DATA_IDX) begin
                        bit_idx_next = '0;
                        if (HAS_PARITY) begin
                            state_next = ST_PARITY;
                            tx_next    = parity;
                        end else begin
                            state_next = ST_STOP;
                            tx_next    = 1'b1;
                        end
                    end else begin
                        bit_idx_next = bit_idx + BIT_IDX_W'(1);
                        shreg_next   = shreg >> 1;
                        tx_next      = shreg_next[0];
                    end
                end
            end
            ST_PARITY: begin
                if (bit_done_c) begin
                    state_next   = ST_STOP;
                    tx_next      = 1'b1;
                    bit_idx_next = '0;
                end
            end
            ST_STOP: begin
                tx_next = 1'b1;
                if (bit_done_c) begin
                    if (bit_idx == LAST_STOP_IDX) begin
                        state_next   = ST_IDLE;
                        busy_next    = 1'b0;
                        bit_idx_next = '0;
                    end else begin
                        bit_idx_next = bit_idx + BIT_IDX_W'(1);
                    end
                end
            end
            default: begin
                state_next   = ST_IDLE;
                tx_next      = 1'b1;
                busy_next    = 1'b0;
                bit_idx_next = '0;
            end
        endcase

        // Ready mirrors the state being entered so it drops on the accepting edge.
        tx_ready_next = (state_next == ST_IDLE) && ena;
    end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: four configurations (8N1, 8E1, 8O1, 8N2) at 4 clocks per bit,
// decoded by a sampling UART model against a queue of expected bytes.
module tb_uart_tx;

    localparam int CPB = 4;
    localparam int ND  = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [ND-1:0] ena;
    logic [ND-1:0] valid;
    logic [7:0]    data_r [ND];
    wire  [ND-1:0] tx_w;
    wire  [ND-1:0] busy_w;
    wire  [ND-1:0] ready_w;

    always #5 clk = ~clk;

    uart_tx #(.CLKS_PER_BIT(CPB), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) dut_8n1 (
        .clk(clk), .rst_n(rst_n), .ena(ena[0]), .tx_data(data_r[0]), .tx_valid(valid[0]),
        .tx_ready(ready_w[0]), .tx(tx_w[0]), .busy(busy_w[0]));
    uart_tx #(.CLKS_PER_BIT(CPB), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) dut_8e1 (
        .clk(clk), .rst_n(rst_n), .ena(ena[1]), .tx_data(data_r[1]), .tx_valid(valid[1]),
        .tx_ready(ready_w[1]), .tx(tx_w[1]), .busy(busy_w[1]));
    uart_tx #(.CLKS_PER_BIT(CPB), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)) dut_8o1 (
        .clk(clk), .rst_n(rst_n), .ena(ena[2]), .tx_data(data_r[2]), .tx_valid(valid[2]),
        .tx_ready(ready_w[2]), .tx(tx_w[2]), .busy(busy_w[2]));
    uart_tx #(.CLKS_PER_BIT(CPB), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(2)) dut_8n2 (
        .clk(clk), .rst_n(rst_n), .ena(ena[3]), .tx_data(data_r[3]), .tx_valid(valid[3]),
        .tx_ready(ready_w[3]), .tx(tx_w[3]), .busy(busy_w[3]));

    typedef struct {
        int         d;
        logic [7:0] b;
    } exp_t;

    typedef struct {
        int         d;
        logic [7:0] b;
        int         exp_busy;
        int         exp_rdy;
        int         exp_par;
    } vec_t;

    exp_t exp_q[$];
    int   n_vec;
    int   n_bad;

    logic mon_act  [ND];
    int   mon_cnt  [ND];
    logic samp     [ND][48];
    int   idle_run [ND];
    int   last_gap [ND];
    int   frames   [ND];
    logic last_par [ND];

    function automatic int nbits(input int d);
        case (d)
            0:       return 10;
            default: return 11;
        endcase
    endfunction

    function automatic logic has_par(input int d);
        return (d == 1) || (d == 2);
    endfunction

    function automatic logic par_odd(input int d);
        return (d == 2);
    endfunction

    function automatic int stops(input int d);
        return (d == 3) ? 2 : 1;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic decode(input int d);
        logic [7:0] b;
        logic       par;
        int         nb;
        int         width_bad;
        int         stop_bad;
        exp_t       e;
        nb = nbits(d);
        width_bad = 0;
        stop_bad = 0;
        b = '0;
        par = 1'b0;
        for (int k = 0; k < nb; k++)
            for (int s = 1; s < CPB; s++)
                if (samp[d][k*CPB+s] !== samp[d][k*CPB]) width_bad++;
        for (int i = 0; i < 8; i++) b[i] = samp[d][(1+i)*CPB];
        if (has_par(d)) par = samp[d][9*CPB];
        for (int k = nb - stops(d); k < nb; k++)
            if (samp[d][k*CPB] !== 1'b1) stop_bad++;
        check("bit_width", 32'(width_bad), 32'd0);
        check("stop_level", 32'(stop_bad), 32'd0);
        if (has_par(d)) check("parity_rule", 32'(par), 32'((^b) ^ par_odd(d)));
        last_par[d] = par;
        frames[d]++;
        if (exp_q.size() == 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL unexpected_frame: dut %0d got 0x%02h, expected none", d, b);
        end else begin
            e = exp_q.pop_front();
            check("frame_dut", 32'(d), 32'(e.d));
            check("frame_byte", 32'(b), 32'(e.b));
        end
    endtask

    // Serial-line model: one sample per clock, on the falling edge.
    task automatic mon_step();
        for (int d = 0; d < ND; d++) begin
            if (!rst_n) begin
                mon_act[d]  = 1'b0;
                idle_run[d] = 0;
            end else if (!mon_act[d]) begin
                if (tx_w[d] == 1'b0) begin
                    mon_act[d]  = 1'b1;
                    last_gap[d] = idle_run[d];
                    samp[d][0]  = 1'b0;
                    mon_cnt[d]  = 1;
                end else begin
                    idle_run[d]++;
                end
            end else begin
                samp[d][mon_cnt[d]] = tx_w[d];
                mon_cnt[d]++;
                if (mon_cnt[d] == nbits(d) * CPB) begin
                    mon_act[d]  = 1'b0;
                    idle_run[d] = 0;
                    decode(d);
                end
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        mon_step();
    endtask

    task automatic push_exp(input int d, input logic [7:0] b);
        exp_t e;
        e.d = d;
        e.b = b;
        exp_q.push_back(e);
    endtask

    task automatic wait_ready(input int d, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (ready_w[d]) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        if (!ok) check("ready_timeout", 32'd0, 32'd1);
    endtask

    // Returns one sample after the accepting edge, with tx_valid dropped.
    task automatic start_frame(input int d, input logic [7:0] b);
        bit ok;
        data_r[d] = b;
        valid[d]  = 1'b1;
        wait_ready(d, ok);
        if (ok) push_exp(d, b);
        tick();
        valid[d] = 1'b0;
    endtask

    task automatic run_frame(input int d, output int busy_cnt, output int ready_at);
        int n;
        n = 1;
        busy_cnt = busy_w[d] ? 1 : 0;
        ready_at = 0;
        while (n < 300) begin
            tick();
            n++;
            if (busy_w[d]) busy_cnt++;
            if (ready_w[d]) begin
                ready_at = n;
                break;
            end
        end
    endtask

    task automatic wait_idle(input int d);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            tick();
            if (!busy_w[d] && !mon_act[d]) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("idle_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        vec_t vecs [8];
        int   busy_cnt;
        int   ready_at;
        int   f0;
        int   cnt_a;
        int   cnt_b;
        int   cnt_c;
        bit   ok;
        exp_t dummy;

        n_vec = 0;
        n_bad = 0;
        rst_n = 1'b0;
        ena   = '1;
        valid = '0;
        for (int d = 0; d < ND; d++) begin
            data_r[d]   = 8'h00;
            mon_act[d]  = 1'b0;
            mon_cnt[d]  = 0;
            idle_run[d] = 0;
            last_gap[d] = -1;
            frames[d]   = 0;
            last_par[d] = 1'b0;
        end

        vecs[0] = '{d: 0, b: 8'h55, exp_busy: 40, exp_rdy: 41, exp_par: -1};
        vecs[1] = '{d: 1, b: 8'h07, exp_busy: 44, exp_rdy: 45, exp_par: 1};
        vecs[2] = '{d: 2, b: 8'h07, exp_busy: 44, exp_rdy: 45, exp_par: 0};
        vecs[3] = '{d: 1, b: 8'hA5, exp_busy: 44, exp_rdy: 45, exp_par: 0};
        vecs[4] = '{d: 2, b: 8'h00, exp_busy: 44, exp_rdy: 45, exp_par: 1};
        vecs[5] = '{d: 3, b: 8'hC3, exp_busy: 44, exp_rdy: 45, exp_par: -1};
        vecs[6] = '{d: 0, b: 8'h00, exp_busy: 40, exp_rdy: 41, exp_par: -1};
        vecs[7] = '{d: 0, b: 8'hFF, exp_busy: 40, exp_rdy: 41, exp_par: -1};

        // Reset state, then ready one cycle after release.
        repeat (3) tick();
        check("rst_tx", 32'(tx_w), 32'hF);
        check("rst_busy", 32'(busy_w), 32'h0);
        check("rst_ready", 32'(ready_w), 32'h0);
        rst_n = 1'b1;
        tick();
        check("ready_after_rst", 32'(ready_w), 32'hF);

        // Table-driven frames across configurations.
        for (int v = 0; v < 8; v++) begin
            start_frame(vecs[v].d, vecs[v].b);
            run_frame(vecs[v].d, busy_cnt, ready_at);
            check("busy_cycles", 32'(busy_cnt), 32'(vecs[v].exp_busy));
            check("ready_cycle", 32'(ready_at), 32'(vecs[v].exp_rdy));
            if (vecs[v].exp_par >= 0)
                check("parity_bit", 32'(last_par[vecs[v].d]), 32'(vecs[v].exp_par));
            repeat (2) tick();
        end

        // Back-to-back with tx_valid held high: exactly one idle-high cycle between frames.
        f0 = frames[0];
        data_r[0] = 8'hA5;
        valid[0]  = 1'b1;
        wait_ready(0, ok);
        if (ok) push_exp(0, 8'hA5);
        tick();
        data_r[0] = 8'h3C;
        wait_ready(0, ok);
        if (ok) push_exp(0, 8'h3C);
        tick();
        valid[0] = 1'b0;
        wait_idle(0);
        check("b2b_gap", 32'(last_gap[0]), 32'd1);
        check("b2b_frames", 32'(frames[0] - f0), 32'd2);
        repeat (2) tick();

        // tx_valid pulsed mid-frame is ignored.
        f0 = frames[0];
        start_frame(0, 8'h12);
        repeat (10) tick();
        data_r[0] = 8'hFF;
        valid[0]  = 1'b1;
        cnt_a = 0;
        repeat (5) begin
            tick();
            if (ready_w[0]) cnt_a++;
        end
        valid[0] = 1'b0;
        wait_idle(0);
        repeat (5) tick();
        check("midframe_ready", 32'(cnt_a), 32'd0);
        check("midframe_frames", 32'(frames[0] - f0), 32'd1);
        check("midframe_idle_tx", 32'(tx_w[0]), 32'd1);

        // Reset during data bit 3 of 0x81 aborts the frame.
        f0 = frames[0];
        start_frame(0, 8'h81);
        repeat (17) tick();
        check("d3_level", 32'(tx_w[0]), 32'd0);
        rst_n = 1'b0;
        tick();
        check("abort_tx", 32'(tx_w[0]), 32'd1);
        check("abort_busy", 32'(busy_w[0]), 32'd0);
        check("abort_ready", 32'(ready_w[0]), 32'd0);
        rst_n = 1'b1;
        if (exp_q.size() > 0) dummy = exp_q.pop_back();
        tick();
        check("abort_ready_rel", 32'(ready_w[0]), 32'd1);
        repeat (3) tick();
        check("abort_no_frame", 32'(frames[0] - f0), 32'd0);
        start_frame(0, 8'h42);
        wait_idle(0);
        check("after_abort_frames", 32'(frames[0] - f0), 32'd1);
        repeat (2) tick();

        // ena low blocks new frames.
        ena[0] = 1'b0;
        tick();
        check("ena_low_ready", 32'(ready_w[0]), 32'd0);
        data_r[0] = 8'h99;
        valid[0]  = 1'b1;
        cnt_a = 0;
        cnt_b = 0;
        cnt_c = 0;
        repeat (20) begin
            tick();
            if (!tx_w[0]) cnt_a++;
            if (ready_w[0]) cnt_b++;
            if (busy_w[0]) cnt_c++;
        end
        check("ena_low_tx", 32'(cnt_a), 32'd0);
        check("ena_low_rdy", 32'(cnt_b), 32'd0);
        check("ena_low_busy", 32'(cnt_c), 32'd0);
        valid[0] = 1'b0;
        ena[0]   = 1'b1;
        tick();
        check("ena_high_ready", 32'(ready_w[0]), 32'd1);

        // ena falls in the same cycle tx_valid meets a high tx_ready: no accept.
        ena[0]    = 1'b0;
        data_r[0] = 8'h77;
        valid[0]  = 1'b1;
        tick();
        check("ena_fall_busy", 32'(busy_w[0]), 32'd0);
        check("ena_fall_tx", 32'(tx_w[0]), 32'd1);
        check("ena_fall_ready", 32'(ready_w[0]), 32'd0);
        valid[0] = 1'b0;
        ena[0]   = 1'b1;
        repeat (2) tick();

        // ena dropped mid-frame on 8N2: frame completes, then ready stays low.
        f0 = frames[3];
        start_frame(3, 8'h5A);
        repeat (8) tick();
        ena[3] = 1'b0;
        wait_idle(3);
        repeat (3) tick();
        check("ena_mid_frames", 32'(frames[3] - f0), 32'd1);
        check("ena_mid_ready", 32'(ready_w[3]), 32'd0);
        check("ena_mid_tx", 32'(tx_w[3]), 32'd1);
        ena[3] = 1'b1;
        repeat (2) tick();

        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
